// File: rtl/memory_controller.sv
// Registered ROM / RAM / MMIO request decoder; one request in flight, one response beat per request.
// Latency: fault 1, ROM 2, RAM 1+RAM_WAIT, MMIO 2+peripheral wait; reqReady low until the response handshakes.
module memory_controller #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    ROM_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE      = ADDR_WIDTH'(32'h0000_1000),
    parameter int                    RAM_WORDS     = 1024,
    parameter int                    RAM_WAIT      = 1,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE     = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [ADDR_WIDTH-1:0] MMIO_SPAN     = ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqWrite,
    input  logic [ADDR_WIDTH-1:0]     reqAddress,
    input  logic [DATA_WIDTH-1:0]     reqWriteData,
    input  logic [DATA_WIDTH/8-1:0]   reqByteEnable,
    output logic                      respValid,
    input  logic                      respReady,
    output logic [DATA_WIDTH-1:0]     respData,
    output logic [1:0]                respFault,
    output logic [ADDR_WIDTH-1:0]     romAddress,
    input  logic [DATA_WIDTH-1:0]     romData,
    output logic                      mmioValid,
    input  logic                      mmioReady,
    output logic                      mmioWrite,
    output logic [ADDR_WIDTH-1:0]     mmioAddress,
    output logic [DATA_WIDTH-1:0]     mmioWriteData,
    output logic [DATA_WIDTH/8-1:0]   mmioByteEnable,
    input  logic [DATA_WIDTH-1:0]     mmioReadData
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(RAM_WORDS);
    localparam int CW    = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);

    // One extra bit so region limits ending at the top of the address space do not wrap.
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] ROM_END = AW1'(1) << ROM_ADDR_BITS;
    localparam logic [AW1-1:0] RAM_LO  = AW1'(RAM_BASE);
    localparam logic [AW1-1:0] RAM_HI  = RAM_LO + AW1'(RAM_WORDS * BYTES);
    localparam logic [AW1-1:0] MMIO_LO = AW1'(MMIO_BASE);
    localparam logic [AW1-1:0] MMIO_HI = MMIO_LO + AW1'(MMIO_SPAN);

    localparam logic [1:0] F_OK    = 2'd0;
    localparam logic [1:0] F_MIS   = 2'd1;
    localparam logic [1:0] F_ROMWR = 2'd2;
    localparam logic [1:0] F_UNMAP = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_RD,
        S_RAM_WAIT,
        S_MMIO,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic [1:0]              resp_fault_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic                    mmio_valid_q;
    logic                    mmio_write_q;
    logic [ADDR_WIDTH-1:0]   mmio_addr_q;
    logic [DATA_WIDTH-1:0]   mmio_wdat_q;
    logic [BYTES-1:0]        mmio_be_q;
    logic                    wr_q;
    logic [IDXW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic [BYTES-1:0]        be_q;
    logic [CW-1:0]           wait_cnt_q;

    logic [DATA_WIDTH-1:0]   mem [RAM_WORDS];

    assign reqReady       = req_ready_q;
    assign respValid      = resp_valid_q;
    assign respData       = resp_data_q;
    assign respFault      = resp_fault_q;
    assign romAddress     = rom_addr_q;
    assign mmioValid      = mmio_valid_q;
    assign mmioWrite      = mmio_write_q;
    assign mmioAddress    = mmio_addr_q;
    assign mmioWriteData  = mmio_wdat_q;
    assign mmioByteEnable = mmio_be_q;

    // Address decode on the live request; only used on the accepting edge.
    logic [AW1-1:0]  req_addr_x;
    logic            misaligned;
    logic            in_rom;
    logic            in_ram;
    logic            in_mmio;
    logic [IDXW-1:0] req_idx;
    logic            accept;

    assign req_addr_x = {1'b0, reqAddress};
    assign misaligned = |reqAddress[OFF-1:0];
    assign in_rom     = req_addr_x < ROM_END;
    assign in_ram     = (req_addr_x >= RAM_LO) && (req_addr_x < RAM_HI);
    assign in_mmio    = (req_addr_x >= MMIO_LO) && (req_addr_x < MMIO_HI);
    assign req_idx    = IDXW'((reqAddress - RAM_BASE) >> OFF);
    assign accept     = reqValid && req_ready_q;

    logic [1:0] dec_fault;
    logic       dec_rom;
    logic       dec_ram;
    logic       dec_mmio;

    always_comb begin
        dec_fault = F_OK;
        dec_rom   = 1'b0;
        dec_ram   = 1'b0;
        dec_mmio  = 1'b0;
        if (misaligned) begin
            dec_fault = F_MIS;
        end else if (in_rom && reqWrite) begin
            dec_fault = F_ROMWR;
        end else if (in_rom) begin
            dec_rom = 1'b1;
        end else if (in_ram) begin
            dec_ram = 1'b1;
        end else if (in_mmio) begin
            dec_mmio = 1'b1;
        end else begin
            dec_fault = F_UNMAP;
        end
    end

    // With no wait states the RAM commits on the accepting edge straight from the request inputs.
    logic                  ram_we;
    logic [IDXW-1:0]       ram_idx;
    logic [DATA_WIDTH-1:0] ram_wdat;
    logic [BYTES-1:0]      ram_be;
    logic [DATA_WIDTH-1:0] ram_rdat;

    always_comb begin
        ram_we   = 1'b0;
        ram_idx  = idx_q;
        ram_wdat = wdat_q;
        ram_be   = be_q;
        if (state_q == S_IDLE) begin
            ram_idx  = req_idx;
            ram_wdat = reqWriteData;
            ram_be   = reqByteEnable;
        end
        if (RAM_WAIT == 0) begin
            ram_we = accept && dec_ram && reqWrite;
        end else begin
            ram_we = (state_q == S_RAM_WAIT) && (wait_cnt_q == WAIT_LAST) && wr_q;
        end
        ram_we = ram_we && resetN;
    end

    assign ram_rdat = mem[ram_idx];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ram_be[b]) begin
                    mem[ram_idx][b*8 +: 8] <= ram_wdat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= F_OK;
            rom_addr_q   <= '0;
            mmio_valid_q <= 1'b0;
            mmio_write_q <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdat_q  <= '0;
            mmio_be_q    <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdat_q       <= '0;
            be_q         <= '0;
            wait_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q  <= 1'b0;
                        rom_addr_q   <= reqAddress;
                        wr_q         <= reqWrite;
                        idx_q        <= req_idx;
                        wdat_q       <= reqWriteData;
                        be_q         <= reqByteEnable;
                        wait_cnt_q   <= '0;
                        resp_data_q  <= '0;
                        resp_fault_q <= dec_fault;
                        if (dec_fault != F_OK) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (dec_rom) begin
                            state_q <= S_ROM_RD;
                        end else if (dec_ram) begin
                            if (RAM_WAIT == 0) begin
                                resp_data_q  <= reqWrite ? '0 : ram_rdat;
                                resp_valid_q <= 1'b1;
                                state_q      <= S_RESP;
                            end else begin
                                state_q <= S_RAM_WAIT;
                            end
                        end else begin
                            mmio_valid_q <= 1'b1;
                            mmio_write_q <= reqWrite;
                            mmio_addr_q  <= reqAddress;
                            mmio_wdat_q  <= reqWriteData;
                            mmio_be_q    <= reqByteEnable;
                            state_q      <= S_MMIO;
                        end
                    end
                end
                S_ROM_RD: begin
                    resp_data_q  <= romData;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RAM_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        resp_data_q  <= wr_q ? '0 : ram_rdat;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                S_MMIO: begin
                    if (mmioReady) begin
                        mmio_valid_q <= 1'b0;
                        resp_data_q  <= mmio_write_q ? '0 : mmioReadData;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (respReady) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Randomized bench for memory_controller against a region-level reference model with directed corner cases.
module tb_memory_controller;

    localparam int RAM_WAIT = 1;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic [3:0]  reqByteEnable;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic [1:0]  respFault;
    logic [31:0] romAddress;
    logic [31:0] romData;
    logic        mmioValid;
    logic        mmioReady;
    logic        mmioWrite;
    logic [31:0] mmioAddress;
    logic [31:0] mmioWriteData;
    logic [3:0]  mmioByteEnable;
    logic [31:0] mmioReadData;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ram_m [1024];

    memory_controller #(.RAM_WAIT(RAM_WAIT)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqByteEnable(reqByteEnable),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respFault(respFault),
        .romAddress(romAddress), .romData(romData),
        .mmioValid(mmioValid), .mmioReady(mmioReady), .mmioWrite(mmioWrite),
        .mmioAddress(mmioAddress), .mmioWriteData(mmioWriteData),
        .mmioByteEnable(mmioByteEnable), .mmioReadData(mmioReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign romData = rom_word(romAddress);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Region-level reference: fault priority, response data and cycles from acceptance to respValid.
    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int dly, input logic [31:0] mrd,
                         output logic [31:0] edat, output logic [1:0] eflt, output int elat, output int emm);
        int idx;
        edat = 0; eflt = 0; elat = 1; emm = 0;
        if (a % 4 != 0) begin
            eflt = 1;
        end else if (a < 32'h1000) begin
            if (w) eflt = 2;
            else begin edat = rom_word(a); elat = 2; end
        end else if (a < 32'h2000) begin
            idx  = int'((a - 32'h1000) / 4);
            elat = 1 + RAM_WAIT;
            if (w) begin
                for (int b = 0; b < 4; b++) if (be[b]) ram_m[idx][b*8 +: 8] = wd[b*8 +: 8];
            end else edat = ram_m[idx];
        end else if (a >= 32'h8000_0000 && a < 32'h8000_1000) begin
            emm  = dly + 1;
            elat = dly + 2;
            if (!w) edat = mrd;
        end else begin
            eflt = 3;
        end
    endtask

    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input int dly, input logic [31:0] mrd, input int hold, output logic [31:0] obs);
        logic [31:0] edat;
        logic [1:0]  eflt;
        int elat, emm, cyc, mm_cyc;
        bit mm_bad, rr_bad, hold_bad, timed_out;
        model(w, a, wd, be, dly, mrd, edat, eflt, elat, emm);
        @(negedge clk);
        chk("req_ready_idle", reqReady, 1);
        reqValid = 1; reqWrite = w; reqAddress = a; reqWriteData = wd; reqByteEnable = be;
        @(negedge clk);
        reqValid = 0; reqWrite = $urandom; reqAddress = $urandom; reqWriteData = $urandom; reqByteEnable = $urandom;
        cyc = 1; mm_cyc = 0; mm_bad = 0; rr_bad = 0;
        while (!respValid && cyc < 20) begin
            mmioReady = 0;
            mmioReadData = $urandom;
            if (reqReady !== 1'b0) rr_bad = 1;
            if (mmioValid) begin
                mm_cyc++;
                if (mmioAddress !== a || mmioWrite !== w || mmioWriteData !== wd || mmioByteEnable !== be)
                    mm_bad = 1;
                if (mm_cyc == dly + 1) begin
                    mmioReady = 1;
                    mmioReadData = mrd;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mmioReady = 0;
        timed_out = !respValid;
        obs = respData;
        chk("resp_timeout", timed_out, 0);
        chk("latency", cyc, elat);
        chk("resp_data", respData, edat);
        chk("resp_fault", respFault, eflt);
        chk("mmio_cycles", mm_cyc, emm);
        chk("mmio_fields", mm_bad, 0);
        chk("req_ready_busy", rr_bad, 0);
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            reqValid = 1; reqWrite = 1; reqAddress = 32'h1000; reqWriteData = 32'hBAD0BAD0; reqByteEnable = 4'hF;
            @(negedge clk);
            if (respValid !== 1'b1 || respData !== edat || respFault !== eflt || reqReady !== 1'b0) hold_bad = 1;
        end
        chk("hold_stable", hold_bad, 0);
        respReady = 1;
        @(negedge clk);
        respReady = 0;
        reqValid = 0;
        chk("post_resp_valid", respValid, 0);
        chk("post_req_ready", reqReady, 1);
    endtask

    function automatic logic [31:0] pool_addr(input int p);
        int idx = (p < 16) ? p : 992 + p;
        return 32'h1000 + 32'(idx * 4);
    endfunction

    logic [31:0] obs;
    logic [31:0] old;

    initial begin
        resetN = 0; reqValid = 0; reqWrite = 0; reqAddress = 0; reqWriteData = 0; reqByteEnable = 0;
        respReady = 0; mmioReady = 0; mmioReadData = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", reqReady, 1);
        chk("rst_resp_valid", respValid, 0);
        chk("rst_mmio_valid", mmioValid, 0);
        chk("rst_resp_data", respData, 0);
        chk("rst_resp_fault", respFault, 0);
        chk("rst_rom_addr", romAddress, 0);
        chk("rst_mmio_fields", {mmioWrite, mmioAddress, mmioWriteData, mmioByteEnable}, 0);
        resetN = 1;

        // Fill the RAM words the random phase will touch (low and high end of the array).
        for (int p = 0; p < 32; p++) do_txn(1, pool_addr(p), $urandom, 4'hF, 0, 0, 0, obs);

        do_txn(0, 32'h10, 0, 0, 0, 0, 0, obs);
        chk("plan_rom", obs, 32'hDEADBEEF);
        do_txn(1, 32'h1000, 32'h11223344, 4'hF, 0, 0, 0, obs);
        do_txn(1, 32'h1000, 32'hAABBCCDD, 4'h5, 0, 0, 0, obs);
        do_txn(0, 32'h1000, 0, 0, 0, 0, 0, obs);
        chk("plan_ram_lanes", obs, 32'h11BB33DD);
        do_txn(1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, obs);
        do_txn(0, 32'h20, 0, 0, 0, 0, 0, obs);
        do_txn(0, 32'h1002, 0, 0, 0, 0, 0, obs);
        do_txn(0, 32'h4000_0000, 0, 0, 0, 0, 0, obs);
        do_txn(0, 32'h0000_0FFC, 0, 0, 0, 0, 0, obs);
        do_txn(0, 32'h0000_2000, 0, 0, 0, 0, 0, obs);
        do_txn(0, 32'h8000_1000, 0, 0, 0, 0, 0, obs);
        do_txn(1, 32'h1FFC, 32'h01020304, 4'h0, 0, 0, 0, obs);
        do_txn(0, 32'h8000_0004, 0, 0, 3, 32'h5A5A5A5A, 0, obs);
        chk("plan_mmio", obs, 32'h5A5A5A5A);
        do_txn(0, 32'h1000, 0, 0, 0, 0, 5, obs);

        // Reset while the peripheral stalls: the transaction is dropped.
        @(negedge clk);
        reqValid = 1; reqWrite = 0; reqAddress = 32'h8000_0008;
        @(negedge clk);
        reqValid = 0;
        @(negedge clk);
        chk("rst_mmio_pre", mmioValid, 1);
        resetN = 0;
        @(negedge clk);
        chk("rst_mid_mmio_valid", mmioValid, 0);
        chk("rst_mid_resp_valid", respValid, 0);
        chk("rst_mid_req_ready", reqReady, 1);
        resetN = 1;

        // Reset on the commit edge of a RAM write: the write must not land.
        old = ram_m[3];
        @(negedge clk);
        reqValid = 1; reqWrite = 1; reqAddress = 32'h100C; reqWriteData = ~old; reqByteEnable = 4'hF;
        @(negedge clk);
        reqValid = 0;
        resetN = 0;
        @(negedge clk);
        resetN = 1;
        do_txn(0, 32'h100C, 0, 0, 0, 0, 0, obs);
        chk("rst_abandoned_write", obs, old);
        do_txn(0, 32'h1000, 0, 0, 0, 0, 0, obs);

        for (int t = 0; t < 250; t++) begin
            int kind = $urandom_range(0, 5);
            logic [31:0] a;
            bit w = $urandom_range(0, 1) == 1;
            case (kind)
                0: begin a = 32'($urandom_range(0, 1023) * 4); w = 0; end
                1: begin a = 32'($urandom_range(0, 1023) * 4); w = 1; end
                2: a = pool_addr($urandom_range(0, 31));
                3: a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                4: case ($urandom_range(0, 3))
                       0: a = 32'h0000_2000;
                       1: a = 32'h8000_1000;
                       2: a = 32'h7FFF_FFFC;
                       default: a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
                   endcase
                default: a = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
            endcase
            do_txn(w, a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom, $urandom_range(0, 2), obs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
